// File: rtl/dmem_arb_pkg.sv
// Shared states, sizing constants and address checking for the data-memory arbiter.
package dmem_arb_pkg;

  localparam int MEM_BYTES  = 1024;
  localparam int ADDR_LIMIT = MEM_BYTES - 8;

  localparam logic REQ_CORE = 1'b0;
  localparam logic REQ_DBG  = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } state_t;

  typedef struct packed {
    logic owner;
    logic we;
    logic err;
  } cmd_t;

  // A doubleword must be 8-byte aligned and lie wholly inside the memory.
  function automatic logic addr_err(input logic [63:0] addr, input logic [63:0] limit);
    return (addr[2:0] != 3'd0) || (addr > limit);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter; last_grant only moves when a grant is taken.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] i_valid,
  input  logic       i_advance,
  output logic       o_winner
);

  import dmem_arb_pkg::*;

  logic r_last_grant;

  always_comb begin
    if (i_valid == 2'b11) begin
      o_winner = ~r_last_grant;
    end else if (i_valid[1]) begin
      o_winner = REQ_DBG;
    end else begin
      o_winner = REQ_CORE;
    end
  end

  // Reset to the debug port so the core wins the first contended grant.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last_grant <= REQ_DBG;
    end else if (i_advance) begin
      r_last_grant <= o_winner;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin front end sharing the single-ported 1 KiB data memory between the
// core MEM stage and the debug/DMA port, with one access in flight at a time.
module dmem_arbiter #(
  parameter int MEM_BYTES = 1024,
  parameter int DATA_W    = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [1:0]        req_we,
  input  logic [63:0]       req_addr0,
  input  logic [63:0]       req_addr1,
  input  logic [DATA_W-1:0] req_wdata0,
  input  logic [DATA_W-1:0] req_wdata1,
  output logic [1:0]        rsp_valid,
  output logic              rsp_err,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [63:0]       mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_MemRead,
  output logic              mem_MemWrite,
  input  logic [DATA_W-1:0] mem_read_data
);

  import dmem_arb_pkg::*;

  localparam logic [63:0] LAST_DW_ADDR = 64'(MEM_BYTES - 8);

  state_t              r_state;
  cmd_t                r_cmd;
  logic [63:0]         r_mem_address;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic                r_mem_read;
  logic                r_mem_write;
  logic [1:0]          r_rsp_valid;
  logic                r_rsp_err;
  logic [DATA_W-1:0]   r_rsp_rdata;

  logic                w_accept;
  logic                w_winner;
  logic                w_hs;
  logic                w_we;
  logic                w_err;
  logic [63:0]         w_addr;
  logic [DATA_W-1:0]   w_wdata;

  rr_arb2 u_arb (
    .clk       (clk),
    .reset     (reset),
    .i_valid   (req_valid),
    .i_advance (w_hs),
    .o_winner  (w_winner)
  );

  assign w_accept  = (r_state == IDLE) || (r_state == RESP);
  assign w_hs      = w_accept && req_valid[w_winner];
  assign req_ready = w_hs ? (w_winner ? 2'b10 : 2'b01) : 2'b00;

  assign w_we    = req_we[w_winner];
  assign w_addr  = w_winner ? req_addr1 : req_addr0;
  assign w_wdata = w_winner ? req_wdata1 : req_wdata0;
  assign w_err   = addr_err(w_addr, LAST_DW_ADDR);

  // Mem strobes and the response are registers cleared every cycle they are not
  // needed, so each lasts exactly one cycle and reset drops them at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= IDLE;
      r_cmd         <= '0;
      r_mem_address <= '0;
      r_mem_wdata   <= '0;
      r_mem_read    <= 1'b0;
      r_mem_write   <= 1'b0;
      r_rsp_valid   <= 2'b00;
      r_rsp_err     <= 1'b0;
      r_rsp_rdata   <= '0;
    end else begin
      r_mem_address <= '0;
      r_mem_wdata   <= '0;
      r_mem_read    <= 1'b0;
      r_mem_write   <= 1'b0;
      r_rsp_valid   <= 2'b00;
      r_rsp_err     <= 1'b0;
      r_rsp_rdata   <= '0;
      case (r_state)
        ISSUE: begin
          r_rsp_valid <= r_cmd.owner ? 2'b10 : 2'b01;
          r_rsp_err   <= r_cmd.err;
          if (!r_cmd.we && !r_cmd.err) begin
            r_rsp_rdata <= mem_read_data;
          end
          r_state <= RESP;
        end
        default: begin
          // A rejected address never reaches the memory, not even as an address.
          if (w_hs) begin
            r_cmd         <= '{owner: w_winner, we: w_we, err: w_err};
            r_mem_address <= w_err ? '0 : w_addr;
            r_mem_wdata   <= w_err ? '0 : w_wdata;
            r_mem_write   <= w_we && !w_err;
            r_mem_read    <= !w_we && !w_err;
            r_state       <= ISSUE;
          end else begin
            r_state <= IDLE;
          end
        end
      endcase
    end
  end

  assign mem_address    = r_mem_address;
  assign mem_write_data = r_mem_wdata;
  assign mem_MemRead    = r_mem_read;
  assign mem_MemWrite   = r_mem_write;
  assign rsp_valid      = r_rsp_valid;
  assign rsp_err        = r_rsp_err;
  assign rsp_rdata      = r_rsp_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: byte-wide big-endian memory, transaction-level reference
// model compared every cycle, plus directed scenarios with literal expectations.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  req_valid = 2'b00;
  logic [1:0]  req_we = 2'b00;
  logic [63:0] req_addr0 = '0;
  logic [63:0] req_addr1 = '0;
  logic [63:0] req_wdata0 = '0;
  logic [63:0] req_wdata1 = '0;
  logic [1:0]  req_ready;
  logic [1:0]  rsp_valid;
  logic        rsp_err;
  logic [63:0] rsp_rdata;
  logic [63:0] mem_address;
  logic [63:0] mem_write_data;
  logic        mem_MemRead;
  logic        mem_MemWrite;
  logic [63:0] mem_read_data;

  dmem_arbiter #(.MEM_BYTES(1024), .DATA_W(64)) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_we         (req_we),
    .req_addr0      (req_addr0),
    .req_addr1      (req_addr1),
    .req_wdata0     (req_wdata0),
    .req_wdata1     (req_wdata1),
    .rsp_valid      (rsp_valid),
    .rsp_err        (rsp_err),
    .rsp_rdata      (rsp_rdata),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_MemRead    (mem_MemRead),
    .mem_MemWrite   (mem_MemWrite),
    .mem_read_data  (mem_read_data)
  );

  always #5 clk = ~clk;

  int errCount = 0;
  int checkCount = 0;

  // The physical memory seen by the DUT: bytes, big-endian, combinational read.
  logic [7:0] benchMem [0:1023];

  always_comb begin
    mem_read_data = '0;
    for (int k = 0; k < 8; k++) begin
      if (mem_address + 64'(k) < 64'd1024) begin
        mem_read_data[63-8*k -: 8] = benchMem[10'(mem_address) + 10'(k)];
      end
    end
  end

  always @(posedge clk) begin
    if (mem_MemWrite) begin
      for (int k = 0; k < 8; k++) begin
        if (mem_address + 64'(k) < 64'd1024) begin
          benchMem[10'(mem_address) + 10'(k)] <= mem_write_data[63-8*k -: 8];
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
    checkCount++;
    if (got !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: one transaction waiting to be issued, one waiting to respond,
  // and a doubleword-indexed memory image.
  typedef struct packed {
    logic        v;
    logic        owner;
    logic        we;
    logic        err;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] rdata;
  } txn_t;

  txn_t        issueT = '0;
  txn_t        respT = '0;
  logic        mLast = 1'b1;
  logic [63:0] refMem [0:127];
  logic        mW;
  logic [1:0]  mExpReady;
  logic        mIssueOk;
  int          cyc = 0;
  int          strobeCnt = 0;
  int          rspCount [2] = '{0, 0};
  logic        lastErr [2];
  logic [63:0] lastRdata [2];
  int          grantQ [$];
  int          issueCyc [$];

  initial begin
    for (int i = 0; i < 1024; i++) benchMem[i] = 8'h00;
    for (int i = 0; i < 128; i++) refMem[i] = 64'h0;
  end

  // Compare process: checks outputs at every negedge, then advances the model by
  // the handshake that the coming rising edge will perform.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        checkOutput("resetReady", req_ready, 64'h0);
        checkOutput("resetRspValid", rsp_valid, 64'h0);
        checkOutput("resetRspErr", rsp_err, 64'h0);
        checkOutput("resetRdata", rsp_rdata, 64'h0);
        checkOutput("resetStrobes", {mem_MemRead, mem_MemWrite}, 64'h0);
        checkOutput("resetAddr", mem_address, 64'h0);
        checkOutput("resetWdata", mem_write_data, 64'h0);
        issueT = '0;
        respT = '0;
        mLast = 1'b1;
      end else begin
        if (req_valid == 2'b11) mW = ~mLast;
        else mW = req_valid[1];
        mExpReady = 2'b00;
        if (!issueT.v && req_valid[mW]) mExpReady[mW] = 1'b1;
        checkOutput("req_ready", req_ready, 64'(mExpReady));
        checkOutput("strobeExclusive", mem_MemRead & mem_MemWrite, 64'h0);

        mIssueOk = issueT.v && !issueT.err;
        checkOutput("mem_MemRead", mem_MemRead, 64'(mIssueOk && !issueT.we));
        checkOutput("mem_MemWrite", mem_MemWrite, 64'(mIssueOk && issueT.we));
        checkOutput("mem_address", mem_address, mIssueOk ? issueT.addr : 64'h0);
        checkOutput("mem_write_data", mem_write_data, mIssueOk ? issueT.wdata : 64'h0);

        checkOutput("rsp_valid", rsp_valid, respT.v ? (respT.owner ? 64'h2 : 64'h1) : 64'h0);
        checkOutput("rsp_err", rsp_err, 64'(respT.v && respT.err));
        checkOutput("rsp_rdata", rsp_rdata, respT.v ? respT.rdata : 64'h0);

        for (int r = 0; r < 2; r++) begin
          if (rsp_valid[r]) begin
            rspCount[r]++;
            lastErr[r] = rsp_err;
            lastRdata[r] = rsp_rdata;
          end
        end
        if (mem_MemRead || mem_MemWrite) begin
          strobeCnt++;
          issueCyc.push_back(cyc);
        end

        respT = issueT;
        respT.rdata = 64'h0;
        if (issueT.v && !issueT.err) begin
          if (issueT.we) refMem[int'(issueT.addr / 8)] = issueT.wdata;
          else respT.rdata = refMem[int'(issueT.addr / 8)];
        end
        issueT = '0;
        if (mExpReady != 2'b00) begin
          issueT.v = 1'b1;
          issueT.owner = mW;
          issueT.we = req_we[mW];
          issueT.addr = mW ? req_addr1 : req_addr0;
          issueT.wdata = mW ? req_wdata1 : req_wdata0;
          issueT.err = (issueT.addr % 8 != 0) || (issueT.addr > 64'd1016);
          mLast = mW;
          grantQ.push_back(int'(mW));
        end
      end
    end
  end

  // Waits (bounded) until requester r sees ready at a negedge.
  task automatic waitReady(input int r);
    bit seen = 0;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge clk);
      if (req_ready[r]) seen = 1;
    end
    checkCount++;
    if (!seen) begin
      errCount++;
      $display("[TB] FAIL readyTimeout: requester %0d got no ready, expected ready within 40 cycles", r);
    end
  endtask

  // Presents one request on requester r and holds it until accepted; returns
  // 1 time unit after the accepting edge (the ISSUE cycle).
  task automatic applyStimulus(input int r, input logic we, input logic [63:0] addr,
                               input logic [63:0] data);
    if (r == 0) begin
      req_addr0 = addr;
      req_wdata0 = data;
    end else begin
      req_addr1 = addr;
      req_wdata1 = data;
    end
    req_we[r] = we;
    req_valid[r] = 1'b1;
    waitReady(r);
    @(posedge clk);
    #1;
    req_valid[r] = 1'b0;
  endtask

  // Waits for the next response to requester r, then resyncs to posedge+1.
  task automatic waitRsp(input int r, output logic err, output logic [63:0] rd);
    int c0 = rspCount[r];
    bit got = 0;
    err = 1'bx;
    rd = 'x;
    for (int n = 0; n < 10 && !got; n++) begin
      @(negedge clk);
      #1;
      if (rspCount[r] != c0) begin
        got = 1;
        err = lastErr[r];
        rd = lastRdata[r];
      end
    end
    checkCount++;
    if (!got) begin
      errCount++;
      $display("[TB] FAIL rspTimeout: requester %0d got no response, expected one within 10 cycles", r);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic randDriver(input int r);
    logic [63:0] a;
    for (int n = 0; n < 40; n++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      if ($urandom_range(0, 7) == 0) a = 64'($urandom_range(0, 2047));
      else a = 64'($urandom_range(0, 127)) << 3;
      applyStimulus(r, 1'($urandom_range(0, 1)), a, {$urandom(), $urandom()});
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  logic        e;
  logic [63:0] d;
  int          g0;
  int          n0;
  int          s0;

  initial begin
    doReset();
    checkOutput("postResetReady", req_ready, 64'h0);
    checkOutput("postResetRsp", rsp_valid, 64'h0);

    $display("[TB] single store then load at 0x010");
    applyStimulus(0, 1'b1, 64'h10, 64'h0123456789ABCDEF);
    @(negedge clk);
    checkOutput("storeMemWrite", mem_MemWrite, 64'h1);
    checkOutput("storeMemRead", mem_MemRead, 64'h0);
    checkOutput("storeAddr", mem_address, 64'h10);
    checkOutput("storeWdata", mem_write_data, 64'h0123456789ABCDEF);
    @(negedge clk);
    checkOutput("storeRspValid", rsp_valid, 64'h1);
    checkOutput("storeRspErr", rsp_err, 64'h0);
    checkOutput("storeRdata", rsp_rdata, 64'h0);
    @(posedge clk);
    #1;
    applyStimulus(0, 1'b0, 64'h10, 64'h0);
    @(negedge clk);
    checkOutput("loadMemRead", mem_MemRead, 64'h1);
    checkOutput("loadAddr", mem_address, 64'h10);
    @(negedge clk);
    checkOutput("loadRspValid", rsp_valid, 64'h1);
    checkOutput("loadRdata", rsp_rdata, 64'h0123456789ABCDEF);
    @(posedge clk);
    #1;

    $display("[TB] async reset during ISSUE of a store to 0x020");
    applyStimulus(0, 1'b1, 64'h20, 64'h5555AAAA5555AAAA);
    checkOutput("abortIssueWrite", mem_MemWrite, 64'h1);
    #2 reset = 1'b1;
    #1;
    checkOutput("abortStrobes", {mem_MemRead, mem_MemWrite}, 64'h0);
    checkOutput("abortAddr", mem_address, 64'h0);
    checkOutput("abortWdata", mem_write_data, 64'h0);
    checkOutput("abortRsp", rsp_valid, 64'h0);
    repeat (2) @(negedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      checkOutput("abortNoRsp", rsp_valid, 64'h0);
    end
    @(posedge clk);
    #1;

    $display("[TB] contention: both requesters loading continuously");
    g0 = grantQ.size();
    n0 = issueCyc.size();
    req_we = 2'b00;
    req_addr0 = 64'h20;
    req_addr1 = 64'h10;
    req_valid = 2'b11;
    for (int i = 0; i < 40 && grantQ.size() < g0 + 4; i++) begin
      @(negedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    req_valid = 2'b00;
    repeat (4) @(negedge clk);
    #1;
    checkOutput("grantCount", 64'(grantQ.size() >= g0 + 4), 64'h1);
    checkOutput("issueCount", 64'(issueCyc.size() >= n0 + 4), 64'h1);
    if (grantQ.size() >= g0 + 4) begin
      for (int k = 0; k < 4; k++) checkOutput("grantOrder", 64'(grantQ[g0 + k]), 64'(k % 2));
    end
    if (issueCyc.size() >= n0 + 4) begin
      for (int k = 0; k < 3; k++)
        checkOutput("issueSpacing", 64'(issueCyc[n0 + k + 1] - issueCyc[n0 + k]), 64'd2);
    end
    checkOutput("abortedStoreLoad", lastRdata[0], 64'h0);
    checkOutput("contendLoad1", lastRdata[1], 64'h0123456789ABCDEF);
    @(posedge clk);
    #1;

    $display("[TB] rejected addresses");
    s0 = strobeCnt;
    applyStimulus(0, 1'b1, 64'h3FC, 64'hDEADBEEFCAFEF00D);
    waitRsp(0, e, d);
    checkOutput("err3FCflag", e, 64'h1);
    checkOutput("err3FCdata", d, 64'h0);
    applyStimulus(1, 1'b1, 64'h3F9, 64'hDEADBEEFCAFEF00D);
    waitRsp(1, e, d);
    checkOutput("err3F9flag", e, 64'h1);
    checkOutput("err3F9data", d, 64'h0);
    applyStimulus(0, 1'b0, 64'h400, 64'h0);
    waitRsp(0, e, d);
    checkOutput("err400flag", e, 64'h1);
    checkOutput("err400data", d, 64'h0);
    checkOutput("errNoStrobes", 64'(strobeCnt - s0), 64'h0);
    applyStimulus(0, 1'b0, 64'h3F8, 64'h0);
    waitRsp(0, e, d);
    checkOutput("after3F8err", e, 64'h0);
    checkOutput("after3F8data", d, 64'h0);

    $display("[TB] top in-range doubleword");
    applyStimulus(0, 1'b1, 64'h3F8, 64'hFFFFFFFFFFFFFFFF);
    waitRsp(0, e, d);
    checkOutput("max3F8storeErr", e, 64'h0);
    applyStimulus(0, 1'b0, 64'h3F8, 64'h0);
    waitRsp(0, e, d);
    checkOutput("max3F8loadErr", e, 64'h0);
    checkOutput("max3F8loadData", d, 64'hFFFFFFFFFFFFFFFF);
    applyStimulus(0, 1'b0, 64'h0, 64'h0);
    waitRsp(0, e, d);
    checkOutput("byte0Untouched", d, 64'h0);

    $display("[TB] mixed requesters: debug store, core load in its RESP cycle");
    req_we[1] = 1'b1;
    req_addr1 = 64'h40;
    req_wdata1 = 64'hAA;
    req_valid[1] = 1'b1;
    waitReady(1);
    @(posedge clk);
    #1;
    req_valid[1] = 1'b0;
    req_we[0] = 1'b0;
    req_addr0 = 64'h40;
    req_valid[0] = 1'b1;
    @(negedge clk);
    checkOutput("mixedIssueReady", req_ready, 64'h0);
    @(negedge clk);
    checkOutput("mixedRespValid", rsp_valid, 64'h2);
    checkOutput("mixedRespReady", req_ready, 64'h1);
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0;
    waitRsp(0, e, d);
    checkOutput("mixedLoadErr", e, 64'h0);
    checkOutput("mixedLoadData", d, 64'h00000000000000AA);

    $display("[TB] randomized traffic on both requesters");
    fork
      randDriver(0);
      randDriver(1);
    join
    repeat (4) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
